// File: rtl/relogio_ajuste_ctrl_pkg.sv
// Shared types and constants for the clock time-setting slice.
// Mode encoding used by the adjust FSM and exported on modo_o.
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HORA = 2'd1,
    SET_MIN  = 2'd2
  } modo_t;

  localparam int MAX_SEG     = 59;
  localparam int MAX_MIN     = 59;
  localparam int MAX_HORA    = 23;
  localparam int CLK_FREQ_HZ = 100_000_000;

endpackage

// File: rtl/relogio_ajuste_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability debouncer and
// rising-edge press detector (press lags the raw edge by CYCLES+3).
module btn_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic nivel_o,
  output logic press_o
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic s1_q, s2_q;
  logic nivel_q, nivel_d;
  logic prev_q;
  logic press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    nivel_d = nivel_q;
    cnt_d   = '0;
    // count consecutive samples that disagree with the accepted level
    if (s2_q != nivel_q) begin
      if (cnt_q >= LAST) nivel_d = s2_q;
      else               cnt_d   = cnt_q + 1'b1;
    end
    press_d = nivel_q & ~prev_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      nivel_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      nivel_q <= nivel_d;
      prev_q  <= nivel_q;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nivel_o = nivel_q;
  assign press_o = press_q;

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// Time-setting controller: buttons -> mode FSM -> hold/inc/clear strobes.
// Define AJUSTE_AUTO_REPEAT_EN to enable hold-to-repeat on btn_inc.
module relogio_ajuste_ctrl
  import relogio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int TIMEOUT_S       = 30
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       tick_1hz_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic       hold_o,
  output logic       inc_min_o,
  output logic       inc_hora_o,
  output logic       clr_seg_o,
  output logic [1:0] modo_o,
  output logic       blink_o
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_S);

  modo_t state_q, state_d;
  logic hold_q, hold_d;
  logic inc_hora_q, inc_hora_d;
  logic inc_min_q, inc_min_d;
  logic clr_q, clr_d;
  logic blink_q, blink_d;
  logic [TW-1:0] to_q, to_d;

  logic p_mode, p_inc, n_mode, n_inc;
  logic set_st, inc_ok, rep_fire, strobe, timeout_hit;
  logic unused_lvl;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .btn_i   (btn_mode_i),
    .nivel_o (n_mode),
    .press_o (p_mode)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .btn_i   (btn_inc_i),
    .nivel_o (n_inc),
    .press_o (p_inc)
  );

  assign set_st = (state_q != RUN);
  assign inc_ok = p_inc & ~p_mode & set_st;
  assign strobe = inc_ok | rep_fire;
  // an accepted press or repeat restarts the idle window, so it beats timeout
  assign timeout_hit = set_st & tick_1hz_i & ~p_mode & ~strobe
                     & (to_q >= TO_LAST);

`ifdef AJUSTE_AUTO_REPEAT_EN
  localparam int RW = $clog2(HOLD_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LOAD = RW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [RW-1:0] rep_q, rep_d;

  assign rep_fire = n_inc & set_st & ~p_mode & ~p_inc
                  & (rep_q >= REP_LAST);

  always_comb begin
    rep_d = '0;
    if (n_inc && set_st && state_d == state_q && !p_inc) begin
      // reload so later strobes come every REPEAT_CYCLES
      if (rep_fire)              rep_d = REP_LOAD;
      else if (rep_q < REP_LAST) rep_d = rep_q + 1'b1;
      else                       rep_d = rep_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rep_q <= '0;
    else         rep_q <= rep_d;
  end

  assign unused_lvl = n_mode;
`else
  assign rep_fire   = 1'b0;
  assign unused_lvl = n_mode ^ n_inc
                    ^ 1'(HOLD_CYCLES) ^ 1'(REPEAT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    if (p_mode) begin
      unique case (state_q)
        RUN:      state_d = SET_HORA;
        SET_HORA: state_d = SET_MIN;
        default:  state_d = RUN;
      endcase
    end else if (timeout_hit) begin
      state_d = RUN;
    end
  end

  always_comb begin
    hold_d     = set_st;
    inc_hora_d = strobe & (state_q == SET_HORA);
    inc_min_d  = strobe & (state_q == SET_MIN);
    clr_d      = (state_q == SET_MIN) & (state_d == RUN);
    blink_d    = blink_q;
    if (state_d == RUN)          blink_d = 1'b0;
    else if (tick_1hz_i && set_st) blink_d = ~blink_q;
    to_d = to_q;
    if (state_d == RUN || state_d != state_q || strobe)
      to_d = '0;
    else if (tick_1hz_i && to_q < TO_MAX)
      to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RUN;
      hold_q     <= 1'b0;
      inc_hora_q <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_q      <= 1'b0;
      blink_q    <= 1'b0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      inc_hora_q <= inc_hora_d;
      inc_min_q  <= inc_min_d;
      clr_q      <= clr_d;
      blink_q    <= blink_d;
      to_q       <= to_d;
    end
  end

  assign modo_o     = state_q;
  assign hold_o     = hold_q;
  assign inc_hora_o = inc_hora_q;
  assign inc_min_o  = inc_min_q;
  assign clr_seg_o  = clr_q;
  assign blink_o    = blink_q;

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// Bench for relogio_ajuste_ctrl: directed scenarios plus random
// button/tick sequences checked against an event-level mode model.
module tb_relogio_ajuste_ctrl;

  localparam int D    = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int TOS  = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tick = 1'b0;
  logic bm = 1'b0;
  logic bi = 1'b0;
  logic hold_o, inc_min_o, inc_hora_o, clr_seg_o, blink_o;
  logic [1:0] modo_o;

  int checks = 0;
  int errors = 0;
  int n_hora = 0, n_min = 0, n_clr = 0;
  int e_hora = 0, e_min = 0, e_clr = 0;
  int m_modo = 0, m_to = 0;
  logic m_blink = 1'b0;

  always #5 clk = ~clk;

  relogio_ajuste_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP),
    .TIMEOUT_S       (TOS)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .tick_1hz_i (tick),
    .btn_mode_i (bm),
    .btn_inc_i  (bi),
    .hold_o     (hold_o),
    .inc_min_o  (inc_min_o),
    .inc_hora_o (inc_hora_o),
    .clr_seg_o  (clr_seg_o),
    .modo_o     (modo_o),
    .blink_o    (blink_o)
  );

  always @(posedge clk) begin
    #2;
    n_hora += int'(inc_hora_o);
    n_min  += int'(inc_min_o);
    n_clr  += int'(clr_seg_o);
    if (inc_hora_o | inc_min_o | clr_seg_o) begin
      checks++;
      assert ($countones({inc_hora_o, inc_min_o, clr_seg_o}) == 1)
      else begin
        errors++;
        $error("FAIL onehot: got %b expected one hot",
               {inc_hora_o, inc_min_o, clr_seg_o});
      end
    end
    if (clr_seg_o) begin
      checks++;
      assert (modo_o === 2'd0 && hold_o === 1'b1)
      else begin
        errors++;
        $error("FAIL clr_cycle: got modo=%0d hold=%b expected 0/1",
               modo_o, hold_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_mode();
    if (m_modo == 2) e_clr++;
    m_modo = (m_modo + 1) % 3;
    m_to = 0;
    if (m_modo == 0) m_blink = 1'b0;
  endtask

  task automatic model_inc();
    if (m_modo == 1) e_hora++;
    if (m_modo == 2) e_min++;
    if (m_modo != 0) m_to = 0;
  endtask

  task automatic model_tick();
    if (m_modo != 0) begin
      m_to++;
      m_blink = ~m_blink;
      if (m_to >= TOS) begin
        if (m_modo == 2) e_clr++;
        m_modo = 0;
        m_blink = 1'b0;
        m_to = 0;
      end
    end
  endtask

  task automatic press(input bit inc);
    if (inc) bi = 1'b1;
    else     bm = 1'b1;
    cyc(D + 6);
    bi = 1'b0;
    bm = 1'b0;
    cyc(D + 8);
    if (inc) model_inc();
    else     model_mode();
  endtask

  task automatic glitch(input bit inc);
    if (inc) bi = 1'b1;
    else     bm = 1'b1;
    cyc(3);
    bi = 1'b0;
    bm = 1'b0;
    cyc(D + 8);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    model_tick();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".modo"}, 32'(modo_o), 32'(m_modo));
    chk({tag, ".hold"}, 32'(hold_o), 32'(m_modo != 0));
    chk({tag, ".blink"}, 32'(blink_o), 32'(m_blink));
    chk({tag, ".n_hora"}, n_hora, e_hora);
    chk({tag, ".n_min"}, n_min, e_min);
    chk({tag, ".n_clr"}, n_clr, e_clr);
  endtask

  initial begin
    int base;
    int got;
    int want;
    bit seen;
    cyc(3);
    chk("rst.modo", 32'(modo_o), 0);
    chk("rst.hold", 32'(hold_o), 0);
    chk("rst.hora", 32'(inc_hora_o), 0);
    chk("rst.min", 32'(inc_min_o), 0);
    chk("rst.clr", 32'(clr_seg_o), 0);
    chk("rst.blink", 32'(blink_o), 0);
    rstn = 1'b1;
    cyc(2);

    // press latency: raw edge + D+3 to press, +1 to state
    bm = 1'b1;
    cyc(D + 3);
    chk("lat.pre", 32'(modo_o), 0);
    cyc(1);
    chk("lat.mode", 32'(modo_o), 1);
    chk("lat.hold_pre", 32'(hold_o), 0);
    cyc(1);
    chk("lat.hold", 32'(hold_o), 1);
    cyc(1);
    bm = 1'b0;
    cyc(D + 8);
    model_mode();
    for (int i = 0; i < 3; i++) press(1'b1);
    check_all("sethora");

    press(1'b0);
    press(1'b1);
    press(1'b1);
    check_all("setmin");
    press(1'b0);
    check_all("back_run");

    glitch(1'b0);
    glitch(1'b1);
    check_all("glitch");

    press(1'b0);
    press(1'b0);
    tick_pulse();
    tick_pulse();
    check_all("to_min2");
    tick_pulse();
    check_all("to_min3");
    press(1'b0);
    tick_pulse();
    tick_pulse();
    tick_pulse();
    check_all("to_hora");

    // hold inc in SET_HORA well past the repeat threshold
    press(1'b0);
    base = n_hora;
    bi = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(1);
      if (inc_hora_o) seen = 1'b1;
    end
    chk("rep.first_seen", 32'(seen), 1);
    cyc(32);
    bi = 1'b0;
    cyc(D + 12);
    got = n_hora - base;
`ifdef AJUSTE_AUTO_REPEAT_EN
    want = 5;
`else
    want = 1;
`endif
    chk("rep.count", got, want);
    e_hora += want;
    m_to = 0;
    press(1'b0);
    press(1'b0);
    check_all("rep_exit");

    // reset in SET_MIN with inc held
    press(1'b0);
    press(1'b0);
    bi = 1'b1;
    cyc(D + 5);
    model_inc();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst.modo", 32'(modo_o), 0);
    chk("arst.hold", 32'(hold_o), 0);
    chk("arst.hora", 32'(inc_hora_o), 0);
    chk("arst.min", 32'(inc_min_o), 0);
    chk("arst.clr", 32'(clr_seg_o), 0);
    chk("arst.blink", 32'(blink_o), 0);
    cyc(2);
    rstn = 1'b1;
    m_modo = 0;
    m_to = 0;
    m_blink = 1'b0;
    cyc(20);
    bi = 1'b0;
    cyc(D + 8);
    check_all("arst_after");

    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 2)      press(1'b0);
      else if (r <= 5) press(1'b1);
      else if (r <= 8) tick_pulse();
      else             glitch(1'($urandom_range(0, 1)));
      check_all($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
